mipi_csi_header_checker: RTL and testbench

MIPI_CSI_HEADER_CHECKER -- requirements
Module: mipi_csi_header_checker

---
 rtl/mipi_csi_header_checker_pkg.sv | 59 +++++
 rtl/mipi_csi_crc16.sv | 33 +++
 rtl/mipi_csi_header_checker.sv | 149 ++++++++++++++
 tb/tb_mipi_csi_header_checker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_header_checker_pkg.sv
// Shared types, constants and header ECC helpers for the CSI-2 header checker.
package mipi_csi_header_checker_pkg;

    // Data types below this value are short packets; at or above it they are long packets.
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [23:0] data;
        logic        corrected;
        logic        uncorrectable;
    } ecc_result_t;

    // Row k holds the data bits that feed parity bit P[k] of the 6-bit Hamming code.
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
    };

    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        for (int k = 0; k < 6; k++) p[k] = ^(d & ECC_MASK[k]);
        return p;
    endfunction

    function automatic ecc_result_t ecc_check(input logic [23:0] d, input logic [5:0] ecc);
        ecc_result_t res;
        logic [5:0]  syn;
        logic [5:0]  col;
        logic        found;
        syn               = ecc_calc(d) ^ ecc;
        res.data          = d;
        res.corrected     = 1'b0;
        res.uncorrectable = 1'b0;
        found             = 1'b0;
        if (syn != 6'd0) begin
            // A one-hot syndrome is a flipped parity bit: data is already correct.
            if ($onehot(syn)) begin
                found = 1'b1;
            end else begin
                for (int i = 0; i < 24; i++) begin
                    for (int k = 0; k < 6; k++) col[k] = ECC_MASK[k][i];
                    if (col == syn) begin
                        res.data[i] = ~d[i];
                        found       = 1'b1;
                    end
                end
            end
            res.corrected     = found;
            res.uncorrectable = ~found;
        end
        return res;
    endfunction

endpackage

// File: rtl/mipi_csi_crc16.sv
// CSI-2 payload CRC-16 (x^16+x^12+x^5+1, reflected, seed 0xFFFF), four bytes per clock.
module mipi_csi_crc16 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  byte_en_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q;

    // crc_o already includes the current beat so the final compare needs no extra cycle.
    always_comb begin
        logic fb;
        crc_o = crc_q;
        for (int b = 0; b < 4; b++) begin
            if (byte_en_i[b]) begin
                for (int k = 0; k < 8; k++) begin
                    fb    = crc_o[0] ^ data_i[8*b+k];
                    crc_o = crc_o >> 1;
                    if (fb) crc_o = crc_o ^ 16'h8408;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || start_i) crc_q <= 16'hFFFF;
        else if (valid_i)       crc_q <= crc_o;
    end

endmodule

// File: rtl/mipi_csi_header_checker.sv
// CSI-2 packet header checker and payload forwarder.
// Optional payload CRC checking is enabled by defining MIPI_CSI_CRC_CHECK_EN.
module mipi_csi_header_checker
    import mipi_csi_header_checker_pkg::*;
#(
    parameter bit ALLOW_ECC_CORRECTION = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        header_valid_o,
    output logic [1:0]  virtual_channel_o,
    output logic [5:0]  data_type_o,
    output logic [15:0] word_count_o,
    output logic        ecc_corrected_o,
    output logic        ecc_error_o,
    output logic        payload_valid_o,
    output logic [31:0] payload_o,
    output logic [3:0]  payload_byte_en_o,
    output logic        packet_end_o,
    output logic        truncated_o,
    output logic        crc_error_o
);
    state_t      state_q;
    logic [16:0] cnt_q, cnt_d;
    ecc_result_t ecc;
    logic        hdr_bad;
    logic [3:0]  beat_en;
    logic        last_beat;
    logic        crc_mismatch;

    // cnt_q counts bytes still owed (payload + 2 CRC); byte i is payload while cnt_q > i+2.
    always_comb begin
        ecc     = ecc_check(data_i[23:0], data_i[29:24]);
        hdr_bad = ecc.uncorrectable | (ecc.corrected & ~ALLOW_ECC_CORRECTION);
        for (int i = 0; i < 4; i++) beat_en[i] = cnt_q > 17'(i + 2);
        last_beat = cnt_q <= 17'd4;
        cnt_d     = last_beat ? 17'd0 : cnt_q - 17'd4;
    end

`ifdef MIPI_CSI_CRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [7:0]  crc_lo_q;
    logic [7:0]  crc_lo, crc_hi;

    mipi_csi_crc16 u_crc (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (state_q == IDLE && data_valid_i),
        .valid_i  (state_q == PAYLOAD && data_valid_i),
        .data_i   (data_i),
        .byte_en_i(beat_en),
        .crc_o    (crc_calc)
    );

    // The received CRC low byte may arrive one word before the high byte.
    always_comb begin
        crc_lo = crc_lo_q;
        crc_hi = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (cnt_q == 17'(i + 2)) crc_lo = data_i[8*i +: 8];
            if (cnt_q == 17'(i + 1)) crc_hi = data_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)                                  crc_lo_q <= 8'd0;
        else if (state_q == PAYLOAD && data_valid_i)  crc_lo_q <= crc_lo;
    end

    assign crc_mismatch = crc_calc != {crc_hi, crc_lo};
`else
    assign crc_mismatch = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q           <= IDLE;
            cnt_q             <= 17'd0;
            header_valid_o    <= 1'b0;
            virtual_channel_o <= 2'd0;
            data_type_o       <= 6'd0;
            word_count_o      <= 16'd0;
            ecc_corrected_o   <= 1'b0;
            ecc_error_o       <= 1'b0;
            payload_valid_o   <= 1'b0;
            payload_o         <= 32'd0;
            payload_byte_en_o <= 4'd0;
            packet_end_o      <= 1'b0;
            truncated_o       <= 1'b0;
            crc_error_o       <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle, so each one lasts exactly one clock.
            header_valid_o    <= 1'b0;
            ecc_corrected_o   <= 1'b0;
            ecc_error_o       <= 1'b0;
            payload_valid_o   <= 1'b0;
            payload_byte_en_o <= 4'd0;
            packet_end_o      <= 1'b0;
            truncated_o       <= 1'b0;
            crc_error_o       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (data_valid_i) begin
                        if (hdr_bad) begin
                            ecc_error_o <= 1'b1;
                            state_q     <= DRAIN;
                        end else begin
                            header_valid_o    <= 1'b1;
                            ecc_corrected_o   <= ecc.corrected;
                            virtual_channel_o <= ecc.data[7:6];
                            data_type_o       <= ecc.data[5:0];
                            word_count_o      <= ecc.data[23:8];
                            if (ecc.data[5:0] < DT_LONG_MIN) begin
                                state_q <= DRAIN;
                            end else begin
                                cnt_q   <= {1'b0, ecc.data[23:8]} + 17'd2;
                                state_q <= PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (!data_valid_i) begin
                        truncated_o <= 1'b1;
                        cnt_q       <= 17'd0;
                        state_q     <= IDLE;
                    end else begin
                        payload_o         <= data_i;
                        payload_byte_en_o <= beat_en;
                        payload_valid_o   <= |beat_en;
                        cnt_q             <= cnt_d;
                        if (last_beat) begin
                            packet_end_o <= 1'b1;
                            crc_error_o  <= crc_mismatch;
                            state_q      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!data_valid_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_header_checker.sv
// Scoreboard bench for mipi_csi_header_checker; expected events are queued as stimulus is driven.
module tb_mipi_csi_header_checker;
    logic        clk = 1'b0;
    logic        reset;
    logic        dv;
    logic [31:0] data;

    logic        u0_hv, u0_corr, u0_err, u0_pv, u0_pend, u0_trunc, u0_crce;
    logic [1:0]  u0_vc;
    logic [5:0]  u0_dt;
    logic [15:0] u0_wc;
    logic [31:0] u0_pl;
    logic [3:0]  u0_be;
    logic        u1_hv, u1_corr, u1_err, u1_pv, u1_pend, u1_trunc, u1_crce;
    logic [1:0]  u1_vc;
    logic [5:0]  u1_dt;
    logic [15:0] u1_wc;
    logic [31:0] u1_pl;
    logic [3:0]  u1_be;

    always #5 clk = ~clk;

    mipi_csi_header_checker #(.ALLOW_ECC_CORRECTION(1'b1)) u0 (
        .clk_i(clk), .reset_i(reset), .data_valid_i(dv), .data_i(data),
        .header_valid_o(u0_hv), .virtual_channel_o(u0_vc), .data_type_o(u0_dt),
        .word_count_o(u0_wc), .ecc_corrected_o(u0_corr), .ecc_error_o(u0_err),
        .payload_valid_o(u0_pv), .payload_o(u0_pl), .payload_byte_en_o(u0_be),
        .packet_end_o(u0_pend), .truncated_o(u0_trunc), .crc_error_o(u0_crce)
    );

    mipi_csi_header_checker #(.ALLOW_ECC_CORRECTION(1'b0)) u1 (
        .clk_i(clk), .reset_i(reset), .data_valid_i(dv), .data_i(data),
        .header_valid_o(u1_hv), .virtual_channel_o(u1_vc), .data_type_o(u1_dt),
        .word_count_o(u1_wc), .ecc_corrected_o(u1_corr), .ecc_error_o(u1_err),
        .payload_valid_o(u1_pv), .payload_o(u1_pl), .payload_byte_en_o(u1_be),
        .packet_end_o(u1_pend), .truncated_o(u1_trunc), .crc_error_o(u1_crce)
    );

    typedef struct packed {
        logic        hv;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic        corr;
        logic        err;
        logic        pv;
        logic [3:0]  be;
        logic [31:0] pl;
        logic        pend;
        logic        trunc;
        logic        crce;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_obs;
    int  checks   = 0;
    int  failures = 0;

    // Syndrome column of each header data bit D0..D23.
    localparam logic [5:0] COLS [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
        6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr_word(input logic [1:0] vc, input logic [5:0] dt,
                                             input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc, vc, dt};
        e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ COLS[i];
        return {2'b00, e, d};
    endfunction

    function automatic logic [15:0] crc_ref(input byte unsigned b[$]);
        logic [15:0] c;
        logic        mix;
        c = 16'hFFFF;
        foreach (b[n]) begin
            for (int k = 0; k < 8; k++) begin
                mix = b[n][k] ^ c[0];
                c   = {mix, c[15:1]} ^ (mix ? 16'h0408 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] bemask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic bit exp_crc_err(input bit bad);
`ifdef MIPI_CSI_CRC_CHECK_EN
        return bad;
`else
        return 1'b0 & bad;
`endif
    endfunction

    function automatic ev_t ev_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                   input logic [15:0] wc, input logic corr);
        ev_t e = '0;
        e.hv = 1'b1; e.vc = vc; e.dt = dt; e.wc = wc; e.corr = corr;
        return e;
    endfunction

    function automatic ev_t ev_err();
        ev_t e = '0;
        e.err = 1'b1;
        return e;
    endfunction

    function automatic ev_t ev_trunc();
        ev_t e = '0;
        e.trunc = 1'b1;
        return e;
    endfunction

    function automatic ev_t ev_beat(input logic [3:0] be, input logic [31:0] w,
                                    input logic pend, input logic crce);
        ev_t e = '0;
        e.pv = |be; e.be = be; e.pl = w & bemask(be); e.pend = pend; e.crce = crce;
        return e;
    endfunction

    function automatic ev_t observe();
        ev_t o = '0;
        o.hv = u0_hv;
        if (u0_hv) begin
            o.vc = u0_vc; o.dt = u0_dt; o.wc = u0_wc;
        end
        o.corr = u0_corr; o.err = u0_err; o.pv = u0_pv; o.be = u0_be;
        o.pl = u0_pl & bemask(u0_be);
        o.pend = u0_pend; o.trunc = u0_trunc; o.crce = u0_crce;
        return o;
    endfunction

    always @(negedge clk) begin
        if (u0_hv === 1'b1 || u0_corr === 1'b1 || u0_err === 1'b1 || u0_pv === 1'b1 ||
            u0_pend === 1'b1 || u0_trunc === 1'b1 || u0_crce === 1'b1) begin
            mon_obs = observe();
            if (exp_q.size() == 0) check("unexpected_event", 96'(mon_obs), 96'd0);
            else                   check("event", 96'(mon_obs), 96'(exp_q.pop_front()));
        end
    end

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        dv   = v;
        data = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_u0"}, 96'({u0_hv, u0_vc, u0_dt, u0_wc, u0_corr, u0_err, u0_pv, u0_pl,
                                 u0_be, u0_pend, u0_trunc, u0_crce}), 96'd0);
        check({tag, "_u1"}, 96'({u1_hv, u1_vc, u1_dt, u1_wc, u1_corr, u1_err, u1_pv, u1_pl,
                                 u1_be, u1_pend, u1_trunc, u1_crce}), 96'd0);
    endtask

    // mode 0: complete packet, 1: drop data_valid after `stop` payload words, 2: reset after `stop`.
    task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input int wc,
                               input bit bad_crc, input int mode, input int stop);
        byte unsigned sb[$];
        logic [15:0]  c;
        logic [31:0]  w;
        logic [3:0]   be;
        bit           pend;
        int           nwords;
        nwords = (wc + 2 + 3) / 4;
        for (int i = 0; i < wc; i++) sb.push_back(8'($urandom));
        c = crc_ref(sb);
        if (bad_crc) c[7:0] = c[7:0] ^ 8'h5A;
        sb.push_back(c[7:0]);
        sb.push_back(c[15:8]);
        while (sb.size() < nwords * 4) sb.push_back(8'($urandom));
        exp_q.push_back(ev_hdr(vc, dt, 16'(wc), 1'b0));
        drive(1'b1, hdr_word(vc, dt, 16'(wc)));
        for (int wi = 0; wi < nwords; wi++) begin
            if (mode != 0 && wi == stop) break;
            w = {sb[4*wi+3], sb[4*wi+2], sb[4*wi+1], sb[4*wi]};
            for (int i = 0; i < 4; i++) be[i] = (4 * wi + i) < wc;
            pend = (wi == nwords - 1);
            if (be != 4'd0 || pend)
                exp_q.push_back(ev_beat(be, w, pend, pend && exp_crc_err(bad_crc)));
            drive(1'b1, w);
        end
        if (mode == 2) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            data  = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_all_zero("reset_mid_packet");
            @(posedge clk);
            #1;
            reset = 1'b0;
            dv    = 1'b0;
        end else begin
            if (mode == 1) exp_q.push_back(ev_trunc());
            drive(1'b0, 32'd0);
            drive(1'b0, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dv    = 1'b0;
        data  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All-zero header: clean short packet, header one cycle after the word.
        exp_q.push_back(ev_hdr(2'd0, 6'h00, 16'h0000, 1'b0));
        drive(1'b1, 32'h0000_0000);
        drive(1'b0, 32'd0);
        @(negedge clk);
        check("hdr0_latency", 96'(u0_hv), 96'd1);
        drive(1'b0, 32'd0);

        // Single-bit error on WC bit 3: corrected, or rejected when correction is off.
        exp_q.push_back(ev_hdr(2'd0, 6'h00, 16'h0000, 1'b1));
        drive(1'b1, 32'h0000_0800);
        drive(1'b0, 32'd0);
        @(negedge clk);
        check("nocorr_ecc_error", 96'(u1_err), 96'd1);
        check("nocorr_no_header", 96'(u1_hv), 96'd0);
        drive(1'b0, 32'd0);

        // Two-bit error: uncorrectable, the rest of the burst is ignored.
        exp_q.push_back(ev_err());
        drive(1'b1, 32'h0000_0003);
        drive(1'b1, $urandom);
        drive(1'b1, $urandom);
        drive(1'b0, 32'd0);
        drive(1'b0, 32'd0);

        send_packet(2'd0, 6'h2B, 10, 1'b0, 0, 0);
        send_packet(2'd0, 6'h2B, 10, 1'b1, 0, 0);
        send_packet(2'd2, 6'h12, 0, 1'b0, 0, 0);
        send_packet(2'd1, 6'h2B, 3, 1'b0, 0, 0);
        send_packet(2'd0, 6'h2B, 100, 1'b0, 1, 5);
        send_packet(2'd3, 6'h24, 100, 1'b0, 2, 2);

        // First burst after the reset decodes normally.
        exp_q.push_back(ev_hdr(2'd1, 6'h05, 16'h1234, 1'b0));
        drive(1'b1, hdr_word(2'd1, 6'h05, 16'h1234));
        drive(1'b1, $urandom);
        drive(1'b0, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 96'(exp_q.size()), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
